// File: rtl/strobe_generator.sv
// ----------------------------------------------------------------------------
// strobe_generator
//
// Purpose:
//    Turns a programmed (period P, count N) request into a train of N
//    single-cycle strobes. The strobes are P+1 enabled cycles apart, and a
//    one-cycle completion pulse follows the last strobe. It is the
//    count-to-events counterpart of an event counter and is used for timer
//    ticks, watchdog ticks and test-pattern sequencing.
//
// Ports:
//    clk_i        clock
//    rst_ni       asynchronous active-low reset
//    clear_i      synchronous abort; returns to IDLE with counters zeroed
//    en_i         count enable; low freezes all counting
//    req_valid_i  request valid
//    req_ready_o  request ready (IDLE and not clearing)
//    period_i     interval P, sampled on handshake
//    num_i        strobe count N, sampled on handshake
//    strobe_o     single-cycle event
//    idx_o        0-based index of the current or next strobe
//    busy_o       high while strobes are being generated
//    done_o       single-cycle completion pulse
// ----------------------------------------------------------------------------
module strobe_generator #(
   parameter int WIDTH     = 16,
   parameter int CNT_WIDTH = 8
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 clear_i,
   input  logic                 en_i,
   input  logic                 req_valid_i,
   output logic                 req_ready_o,
   input  logic [WIDTH-1:0]     period_i,
   input  logic [CNT_WIDTH-1:0] num_i,
   output logic                 strobe_o,
   output logic [CNT_WIDTH-1:0] idx_o,
   output logic                 busy_o,
   output logic                 done_o
);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t                r_state;
   logic [WIDTH-1:0]      r_interval;
   logic [WIDTH-1:0]      r_period;
   logic [CNT_WIDTH-1:0]  r_remaining;
   logic [CNT_WIDTH-1:0]  r_idx;
   logic                  r_done;

   logic                  w_run;
   logic                  w_interval_zero;
   logic                  w_last;
   logic                  w_accept;

   assign w_run           = (r_state == ST_RUN);
   assign w_interval_zero = (r_interval == '0);
   // remaining is never 0 while in RUN, so ==1 marks the final strobe
   assign w_last          = (r_remaining == CNT_WIDTH'(1));

   assign req_ready_o = (r_state == ST_IDLE) & ~clear_i;
   assign w_accept    = req_valid_i & req_ready_o;

   // Combinational from registers and en_i; clear_i masks it in the abort cycle
   assign strobe_o = w_run & en_i & w_interval_zero & ~clear_i;
   assign idx_o    = r_idx;
   assign busy_o   = w_run;
   assign done_o   = r_done;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state     <= ST_IDLE;
         r_interval  <= '0;
         r_period    <= '0;
         r_remaining <= '0;
         r_idx       <= '0;
         r_done      <= 1'b0;
      end else begin
         // done is a one-cycle pulse unless set again below
         r_done <= 1'b0;
         if (clear_i) begin
            // abort wins over everything, including a pending completion
            r_state     <= ST_IDLE;
            r_interval  <= '0;
            r_period    <= '0;
            r_remaining <= '0;
            r_idx       <= '0;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (w_accept) begin
                     if (num_i == '0) begin
                        // empty request completes at once without strobes
                        r_done <= 1'b1;
                     end else begin
                        r_state     <= ST_RUN;
                        r_interval  <= period_i;
                        r_period    <= period_i;
                        r_remaining <= num_i;
                        r_idx       <= '0;
                     end
                  end
               end
               ST_RUN: begin
                  if (en_i) begin
                     if (w_interval_zero) begin
                        // strobe cycle: reload the interval and advance
                        r_interval  <= r_period;
                        r_idx       <= r_idx + CNT_WIDTH'(1);
                        r_remaining <= r_remaining - CNT_WIDTH'(1);
                        if (w_last) begin
                           r_state <= ST_IDLE;
                           r_done  <= 1'b1;
                        end
                     end else begin
                        r_interval <= r_interval - WIDTH'(1);
                     end
                  end
               end
               default: r_state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_strobe_generator.sv
// ----------------------------------------------------------------------------
// tb_strobe_generator
//
// Purpose:
//    Directed bench for strobe_generator (WIDTH=4 so the maximum period is
//    reachable quickly). A behavioural model tracks each job as a count of
//    enabled cycles and derives strobes by division; it is compared against
//    the DUT on every falling edge. Directed vectors carry hand-computed
//    per-cycle expectations that pin the model.
// ----------------------------------------------------------------------------
module tb_strobe_generator;

   localparam int W  = 4;
   localparam int CW = 8;

   logic          clk;
   logic          rst_n;
   logic          clear;
   logic          en;
   logic          valid;
   logic          ready;
   logic [W-1:0]  period;
   logic [CW-1:0] num;
   logic          strobe;
   logic [CW-1:0] idx;
   logic          busy;
   logic          done;

   int checks = 0;
   int errors = 0;

   strobe_generator #(.WIDTH(W), .CNT_WIDTH(CW)) u_dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .clear_i     (clear),
      .en_i        (en),
      .req_valid_i (valid),
      .req_ready_o (ready),
      .period_i    (period),
      .num_i       (num),
      .strobe_o    (strobe),
      .idx_o       (idx),
      .busy_o      (busy),
      .done_o      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, got, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   // A job is described by its period, count and the number of enabled
   // cycles spent in it; strobe k (1-based) lands on enabled cycle k*(P+1).
   bit m_active;
   int m_p;
   int m_n;
   int m_e;
   int m_idx_hold;
   bit m_done;

   function automatic bit exp_strobe();
      return m_active && en && !clear && (((m_e + 1) % (m_p + 1)) == 0);
   endfunction

   function automatic int exp_idx();
      return m_active ? (m_e / (m_p + 1)) : m_idx_hold;
   endfunction

   always @(posedge clk or negedge rst_n) begin : model_upd
      bit s;
      int e_new;
      if (!rst_n) begin
         m_active   <= 1'b0;
         m_p        <= 0;
         m_n        <= 0;
         m_e        <= 0;
         m_idx_hold <= 0;
         m_done     <= 1'b0;
      end else begin
         s     = exp_strobe();
         e_new = m_e + ((m_active && en) ? 1 : 0);
         m_done <= 1'b0;
         if (clear) begin
            m_active   <= 1'b0;
            m_e        <= 0;
            m_idx_hold <= 0;
         end else if (m_active) begin
            m_e <= e_new;
            if (s && (e_new / (m_p + 1)) == m_n) begin
               m_active   <= 1'b0;
               m_idx_hold <= m_n;
               m_done     <= 1'b1;
            end
         end else if (valid) begin
            if (num == 0) begin
               m_done <= 1'b1;
            end else begin
               m_active <= 1'b1;
               m_p      <= int'(period);
               m_n      <= int'(num);
               m_e      <= 0;
            end
         end
      end
   end

   always @(negedge clk) begin
      chk("mdl_strobe", int'(strobe), int'(exp_strobe()));
      chk("mdl_idx",    int'(idx),    exp_idx());
      chk("mdl_busy",   int'(busy),   int'(m_active));
      chk("mdl_ready",  int'(ready),  int'(!m_active && !clear));
      chk("mdl_done",   int'(done),   int'(m_done));
   end

   // ---------------- directed vectors ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Bit c of each mask applies to cycle c (cycle 0 = first cycle of the run).
   // p2/n2 replace p1/n1 from cycle sw onward.
   task automatic run_test(input int len, input int p1, input int n1,
                           input int p2, input int n2, input int sw,
                           input logic [31:0] vm, input logic [31:0] enlow,
                           input logic [31:0] cm, input logic [31:0] sm,
                           input logic [31:0] dm, input logic [31:0] bm);
      int k;
      k = 0;
      for (int c = 0; c < len; c++) begin
         period = W'((c < sw) ? p1 : p2);
         num    = CW'((c < sw) ? n1 : n2);
         valid  = vm[c];
         en     = ~enlow[c];
         clear  = cm[c];
         #1;
         chk("lit_strobe", int'(strobe), int'(sm[c]));
         chk("lit_done",   int'(done),   int'(dm[c]));
         chk("lit_busy",   int'(busy),   int'(bm[c]));
         chk("lit_ready",  int'(ready),  int'(!bm[c] && !cm[c]));
         if (sm[c]) begin
            chk("lit_idx", int'(idx), k);
            k++;
         end
         if (vm[c] && !bm[c] && !cm[c]) k = 0;
         tick();
      end
      valid = 1'b0;
      clear = 1'b0;
      en    = 1'b1;
      tick();
      tick();
   endtask

   initial begin
      rst_n  = 1'b0;
      clear  = 1'b0;
      en     = 1'b1;
      valid  = 1'b0;
      period = '0;
      num    = '0;
      tick();
      tick();
      chk("rst_ready",  int'(ready),  1);
      chk("rst_busy",   int'(busy),   0);
      chk("rst_strobe", int'(strobe), 0);
      chk("rst_done",   int'(done),   0);
      chk("rst_idx",    int'(idx),    0);
      rst_n = 1'b1;
      tick();

      // P=3 N=2: strobes 4,8; done 9; busy 1..8
      run_test(11, 3, 2, 3, 2, 99, 32'h1, 32'h0, 32'h0,
               32'h110, 32'h200, 32'h1FE);
      // P=0 N=4 then back-to-back P=1 N=1 at cycle 5
      run_test(10, 0, 4, 1, 1, 5, 32'h21, 32'h0, 32'h0,
               32'h9E, 32'h120, 32'hDE);
      // N=0: done in cycle 1, never busy
      run_test(4, 5, 0, 5, 0, 99, 32'h1, 32'h0, 32'h0,
               32'h0, 32'h2, 32'h0);
      // P=2 N=1, en low in cycles 2..4: strobe 6, done 7
      run_test(9, 2, 1, 2, 1, 99, 32'h1, 32'h1C, 32'h0,
               32'h40, 32'h80, 32'h7E);
      // P=1 N=5, clear in cycle 4 with valid held; accepted in cycle 5
      run_test(10, 1, 5, 1, 1, 4, 32'h31, 32'h0, 32'h10,
               32'h84, 32'h100, 32'hDE);
      // P=15 (max) N=1: strobe 16, done 17
      run_test(19, 15, 1, 15, 1, 99, 32'h1, 32'h0, 32'h0,
               32'h10000, 32'h20000, 32'h1FFFE);

      // P=15 N=1 with asynchronous reset in cycle 10
      period = W'(15);
      num    = CW'(1);
      valid  = 1'b1;
      tick();
      valid = 1'b0;
      repeat (9) tick();
      chk("pre_rst_busy", int'(busy), 1);
      rst_n = 1'b0;
      #1;
      chk("arst_busy",   int'(busy),   0);
      chk("arst_ready",  int'(ready),  1);
      chk("arst_strobe", int'(strobe), 0);
      chk("arst_done",   int'(done),   0);
      chk("arst_idx",    int'(idx),    0);
      tick();
      rst_n = 1'b1;
      tick();

      // P=0 N=255: idx reaches 254 on the final strobe, done right after
      period = W'(0);
      num    = CW'(255);
      valid  = 1'b1;
      tick();
      valid = 1'b0;
      for (int c = 1; c <= 256; c++) begin
         if (c == 255) begin
            chk("max_n_strobe", int'(strobe), 1);
            chk("max_n_idx",    int'(idx),    254);
         end
         if (c == 256) begin
            chk("max_n_done", int'(done), 1);
            chk("max_n_busy", int'(busy), 0);
         end
         tick();
      end
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
